// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the simple RV32 core.
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_W = 4,
  parameter int unsigned RETIRE_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ins_ADD,
  input  logic                ins_SUB,
  input  logic                ins_SW,
  input  logic                ins_LW,
  input  logic                ins_ADDI,
  input  logic                ins_LUI,
  input  logic                ins_JAL,
  input  logic [1:0]          cnt_set,
  input  logic                stop,
  input  logic                mem_ready,
  output logic                ir_we,
  output logic                pc_we,
  output logic                pc_sel_jal,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                alu_sub,
  output logic                alu_src_imm,
  output logic                mem_req,
  output logic                mem_we,
  output logic                halted,
  output logic                err_timeout,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Stall number 2**TIMEOUT_W-1 is the one that times out, i.e. when the
  // counter already holds 2**TIMEOUT_W-2 on entry to a stalled cycle.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  state_t               state, state_nx;
  logic [1:0]           step, step_nx;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_nx;
  logic                 err_nx;
  logic                 stall;
  logic                 commit;
  logic                 is_mem;

  assign is_mem = ins_LW | ins_SW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      step        <= step_nx;
      wait_cnt    <= wait_nx;
      err_timeout <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    step_nx     = step;
    wait_nx     = '0;
    err_nx      = err_timeout;
    stall       = 1'b0;
    commit      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel_jal  = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;
    alu_sub     = 1'b0;
    alu_src_imm = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    halted      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      S_DECODE: begin
        if (stop) begin
          state_nx = S_HALT;
        end else begin
          step_nx  = (cnt_set == 2'd0) ? 2'd1 : cnt_set;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_imm = ins_ADDI | ins_LW | ins_SW;
        alu_sub     = ins_SUB;
        if (step > 2'd1) begin
          step_nx = step - 2'd1;
        end else begin
          if (is_mem) begin
            mem_req = 1'b1;
            mem_we  = ins_SW;
          end
          if (is_mem && !mem_ready) begin
            stall = 1'b1;
          end else begin
            commit     = 1'b1;
            pc_we      = 1'b1;
            reg_we     = ins_ADD | ins_SUB | ins_ADDI | ins_LUI | ins_JAL | ins_LW;
            pc_sel_jal = ins_JAL;
            if (ins_LW)       wb_sel = 2'd1;
            else if (ins_LUI) wb_sel = 2'd2;
            else if (ins_JAL) wb_sel = 2'd3;
            state_nx   = S_FETCH;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (stall) begin
      if (wait_cnt == WAIT_LAST) begin
        err_nx   = 1'b1;
        state_nx = S_HALT;
      end else begin
        wait_nx = wait_cnt + 1'b1;
      end
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired <= '0;
    else if (commit) retired <= retired + 1'b1;
  end
`else
  logic commit_unused;
  assign commit_unused = commit;
  assign retired       = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-instruction expected cycle
// sequences generated from the instruction's timing rules and compared each cycle.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  ins = '0;   // {JAL,LUI,ADDI,LW,SW,SUB,ADD}
  logic [1:0]  cnt_set = '0;
  logic        stop = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_we, pc_we, pc_sel_jal, reg_we, alu_sub, alu_src_imm;
  logic        mem_req, mem_we, halted, err_timeout;
  logic [1:0]  wb_sel;
  logic [31:0] retired;
  logic [11:0] outs;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_ret = '0;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_SW = 2, OP_LW = 3,
                 OP_ADDI = 4, OP_LUI = 5, OP_JAL = 6, OP_NONE = 7;

  multicycle_control_unit #(.TIMEOUT_W(4), .RETIRE_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ins_ADD(ins[0]), .ins_SUB(ins[1]), .ins_SW(ins[2]), .ins_LW(ins[3]),
    .ins_ADDI(ins[4]), .ins_LUI(ins[5]), .ins_JAL(ins[6]),
    .cnt_set(cnt_set), .stop(stop), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel_jal(pc_sel_jal), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_sub(alu_sub), .alu_src_imm(alu_src_imm),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
    .err_timeout(err_timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  assign outs = {ir_we, pc_we, pc_sel_jal, reg_we, wb_sel, alu_sub, alu_src_imm,
                 mem_req, mem_we, halted, err_timeout};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] mk(input logic ir, input logic pcw, input logic jal,
                                     input logic rw, input logic [1:0] wb, input logic sub,
                                     input logic imm, input logic req, input logic we,
                                     input logic h, input logic to);
    return {ir, pcw, jal, rw, wb, sub, imm, req, we, h, to};
  endfunction

  function automatic logic [31:0] ret_model();
`ifdef CTRL_RETIRE_CNT_EN
    return exp_ret;
`else
    return 32'd0;
`endif
  endfunction

  // One clock: drive inputs on the falling edge, compare shortly after, then cross the rising edge.
  task automatic cyc(input logic [6:0] ins_v, input logic [1:0] cs, input logic st,
                     input logic rdy, input logic stt, input logic [11:0] exp_o,
                     input logic commit, input string tag);
    @(negedge clk);
    ins = ins_v; cnt_set = cs; stop = st; mem_ready = rdy; start = stt;
    #1;
    check(tag, outs, exp_o);
    check({tag, "_retired"}, retired, ret_model());
    @(posedge clk);
    if (commit) exp_ret++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    #1;
    check("reset_outs", outs, 12'd0);
    check("reset_retired", retired, 32'd0);
    exp_ret = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected cycles of one instruction starting from FETCH.
  task automatic do_instr(input int op, input logic [1:0] cs, input int fst, input int mst);
    logic [6:0] iv;
    logic       imm, sub, ismem, isw, rw, jal;
    logic [1:0] wb;
    int         n;
    iv    = (op < 7) ? 7'(1 << op) : 7'd0;
    imm   = (op == OP_SW) || (op == OP_LW) || (op == OP_ADDI);
    sub   = (op == OP_SUB);
    ismem = (op == OP_SW) || (op == OP_LW);
    isw   = (op == OP_SW);
    jal   = (op == OP_JAL);
    rw    = (op != OP_SW) && (op != OP_NONE);
    wb    = (op == OP_LW) ? 2'd1 : (op == OP_LUI) ? 2'd2 : (op == OP_JAL) ? 2'd3 : 2'd0;
    n     = (cs == 2'd0) ? 1 : int'(cs);
    for (int i = 0; i < fst; i++)
      cyc(iv, cs, 1'b0, 1'b0, 1'($urandom), mk(0,0,0,0,2'd0,0,0,1,0,0,0), 1'b0, "fetch_wait");
    cyc(iv, cs, 1'b0, 1'b1, 1'($urandom), mk(1,0,0,0,2'd0,0,0,1,0,0,0), 1'b0, "fetch");
    cyc(iv, cs, 1'b0, 1'($urandom), 1'($urandom), 12'd0, 1'b0, "decode");
    for (int i = 1; i < n; i++)
      cyc(iv, cs, 1'b0, 1'($urandom), 1'($urandom), mk(0,0,0,0,2'd0,sub,imm,0,0,0,0), 1'b0, "exec_setup");
    if (ismem)
      for (int i = 0; i < mst; i++)
        cyc(iv, cs, 1'b0, 1'b0, 1'($urandom), mk(0,0,0,0,2'd0,sub,imm,1,isw,0,0), 1'b0, "exec_stall");
    cyc(iv, cs, 1'b0, ismem ? 1'b1 : 1'($urandom), 1'($urandom),
        mk(0,1,jal,rw,wb,sub,imm,ismem,isw,0,0), 1'b1, "commit");
  endtask

  initial begin
    int op, fst, mst;
    logic [1:0] cs;

    #1;
    check("por_outs", outs, 12'd0);
    check("por_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cyc('0, 2'd0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, "idle");
    cyc('0, 2'd0, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, "idle");
    cyc('0, 2'd0, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0, "idle_start");

    do_instr(OP_ADD,  2'd1, 0, 0);
    do_instr(OP_SUB,  2'd3, 0, 0);
    do_instr(OP_LW,   2'd2, 0, 3);
    do_instr(OP_JAL,  2'd1, 0, 0);
    do_instr(OP_LUI,  2'd0, 1, 0);
    do_instr(OP_SW,   2'd1, 0, 1);
    do_instr(OP_NONE, 2'd2, 0, 0);
    do_instr(OP_ADD,  2'd1, 14, 0);
    do_instr(OP_LW,   2'd1, 0, 14);

    for (int k = 0; k < 40; k++) begin
      op  = int'($urandom_range(7, 0));
      cs  = 2'($urandom);
      fst = ($urandom_range(7, 0) == 0) ? 14 : int'($urandom_range(3, 0));
      mst = ($urandom_range(7, 0) == 0) ? 14 : int'($urandom_range(4, 0));
      do_instr(op, cs, fst, mst);
    end

    // Decoder stop: HALT, start ignored, only reset leaves.
    cyc(7'd1, 2'd1, 1'b0, 1'b1, 1'b0, mk(1,0,0,0,2'd0,0,0,1,0,0,0), 1'b0, "stop_fetch");
    cyc(7'd1, 2'd1, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0, "stop_decode");
    for (int i = 0; i < 3; i++)
      cyc(7'd1, 2'd1, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,2'd0,0,0,0,0,1,0), 1'b0, "stop_halt");
    do_reset();

    // FETCH timeout after 15 stalled cycles.
    cyc('0, 2'd0, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0, "to_idle");
    for (int i = 0; i < 15; i++)
      cyc('0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2'd0,0,0,1,0,0,0), 1'b0, "to_fetch_wait");
    for (int i = 0; i < 3; i++)
      cyc('0, 2'd0, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,2'd0,0,0,0,0,1,1), 1'b0, "to_fetch_halt");
    do_reset();

    // EXEC timeout on a SW that never completes.
    cyc('0, 2'd0, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0, "to2_idle");
    cyc(7'd4, 2'd1, 1'b0, 1'b1, 1'b0, mk(1,0,0,0,2'd0,0,0,1,0,0,0), 1'b0, "to2_fetch");
    cyc(7'd4, 2'd1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, "to2_decode");
    for (int i = 0; i < 15; i++)
      cyc(7'd4, 2'd1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2'd0,0,1,1,1,0,0), 1'b0, "to2_stall");
    cyc(7'd4, 2'd1, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,2'd0,0,0,0,0,1,1), 1'b0, "to2_halt");
    do_reset();

    // Reset in the middle of a multi-cycle EXEC.
    cyc('0, 2'd0, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0, "mid_idle");
    cyc(7'd2, 2'd3, 1'b0, 1'b1, 1'b0, mk(1,0,0,0,2'd0,0,0,1,0,0,0), 1'b0, "mid_fetch");
    cyc(7'd2, 2'd3, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, "mid_decode");
    cyc(7'd2, 2'd3, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2'd0,1,0,0,0,0,0), 1'b0, "mid_setup");
    do_reset();
    cyc('0, 2'd0, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0, "post_idle");
    do_instr(OP_ADDI, 2'd2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
